// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, field widths, flag indices and state encoding for calc_sequencer
package calc_pkg;

    localparam int OPC_W   = 3;
    localparam int IMM_W   = 8;
    localparam int PC_W    = 4;
    localparam int INSTR_W = OPC_W + IMM_W;

    localparam logic [OPC_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OPC_W-1:0] OP_PUSH = 3'b001;
    localparam logic [OPC_W-1:0] OP_POP  = 3'b010;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b011;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b100;
    localparam logic [OPC_W-1:0] OP_MUL  = 3'b101;
    localparam logic [OPC_W-1:0] OP_JMP  = 3'b110;
    localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

    localparam int FLAG_OVF   = 0;
    localparam int FLAG_FULL  = 1;
    localparam int FLAG_EMPTY = 2;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_ROMWAIT = 4'd2,
        ST_ISSUE   = 4'd3,
        ST_DPWAIT  = 4'd4,
        ST_ADVANCE = 4'd5,
        ST_PAUSE   = 4'd6,
        ST_HALT    = 4'd7,
        ST_FAULT   = 4'd8
    } state_e;

    function automatic logic [OPC_W-1:0] instr_opc(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1:IMM_W];
    endfunction

    function automatic logic [IMM_W-1:0] instr_imm(input logic [INSTR_W-1:0] instr);
        return instr[IMM_W-1:0];
    endfunction

endpackage

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - instruction fetch/decode sequencer driving the stack/ALU datapath
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int ROM_LAT = 1,
    parameter int PC_WRAP = 1
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               run,
    input  logic               step,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_q,
    output logic               dp_valid,
    output logic [OPC_W-1:0]   dp_op,
    output logic [IMM_W-1:0]   dp_imm,
    input  logic               dp_ready,
    input  logic               dp_done,
    input  logic [2:0]         dp_flags,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         overflow,
    output logic               busy,
    output logic               halted
);

    localparam logic [1:0] LAT_LOAD = 2'(ROM_LAT - 1);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [2:0]           ovf_q, ovf_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [1:0]           lat_q, lat_d;
    logic                 flag_any;

    assign flag_any = dp_flags[FLAG_OVF] | dp_flags[FLAG_FULL] | dp_flags[FLAG_EMPTY];

    // State and datapath registers; reset abandons any in-flight command.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ovf_q   <= '0;
            ir_q    <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            ir_q    <= ir_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic: fetch, wait out ROM latency, decode, hand off or execute locally.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        ir_d    = ir_q;
        lat_d   = lat_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_FAULT: begin
                if (run) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    ovf_d   = '0;
                end
            end
            ST_FETCH: begin
                lat_d   = LAT_LOAD;
                state_d = ST_ROMWAIT;
            end
            ST_ROMWAIT: begin
                if (lat_q != 2'd0) begin
                    lat_d = lat_q - 2'd1;
                end else begin
                    ir_d = rom_q;
                    case (instr_opc(rom_q))
                        OP_NOP:  state_d = ST_ADVANCE;
                        OP_JMP: begin
                            pc_d    = rom_q[PC_W-1:0];
                            state_d = step ? ST_PAUSE : ST_FETCH;
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: state_d = ST_ISSUE;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (dp_ready) state_d = ST_DPWAIT;
            end
            ST_DPWAIT: begin
                if (dp_done) begin
                    ovf_d   = ovf_q | dp_flags;
                    state_d = flag_any ? ST_FAULT : ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (pc_q == '1 && PC_WRAP == 0) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = step ? ST_PAUSE : ST_FETCH;
                end
            end
            ST_PAUSE: begin
                if (run) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign overflow = ovf_q;
    assign dp_valid = (state_q == ST_ISSUE);
    assign dp_op    = dp_valid ? instr_opc(ir_q) : '0;
    assign dp_imm   = (dp_valid && instr_opc(ir_q) == OP_PUSH) ? instr_imm(ir_q) : '0;
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_ROMWAIT) ||
                      (state_q == ST_ISSUE) || (state_q == ST_DPWAIT);
    assign halted   = (state_q == ST_HALT) || (state_q == ST_FAULT);

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        step;
    logic [10:0] prog [16];

    logic        auto_mode;
    logic        man_ready;
    logic        man_done;
    logic [2:0]  man_flags;
    logic [2:0]  fault_op;
    logic [2:0]  fault_flags;

    logic [2:0]       halted_v;
    logic [2:0]       busy_v;
    logic [2:0]       valid_v;
    logic [2:0][3:0]  pc_v;
    logic [2:0][2:0]  ovf_v;
    logic [2:0][2:0]  op_v;
    logic [2:0][7:0]  imm_v;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: ROM_LAT=1 wrap; 1: ROM_LAT=1 no wrap; 2: ROM_LAT=2 wrap.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [3:0]  addr_w;
        logic [10:0] q_w;
        logic [3:0]  addr_d;
        logic        valid_w;
        logic [2:0]  op_w;
        logic [7:0]  imm_w;
        logic        ready_w;
        logic        done_w;
        logic [2:0]  flags_w;
        logic [3:0]  pc_w;
        logic [2:0]  ovf_w;
        logic        busy_w;
        logic        halted_w;
        logic        done_a;
        logic [2:0]  flags_a;
        logic [10:0] log_q [$];
        int          vcnt = 0;

        calc_sequencer #(.ROM_LAT((g == 2) ? 2 : 1), .PC_WRAP((g == 1) ? 0 : 1)) u_dut (
            .CLOCK_50 (clk),
            .reset_n  (reset_n),
            .run      (run),
            .step     (step),
            .rom_addr (addr_w),
            .rom_q    (q_w),
            .dp_valid (valid_w),
            .dp_op    (op_w),
            .dp_imm   (imm_w),
            .dp_ready (ready_w),
            .dp_done  (done_w),
            .dp_flags (flags_w),
            .pc       (pc_w),
            .overflow (ovf_w),
            .busy     (busy_w),
            .halted   (halted_w)
        );

        always @(posedge clk) begin
            addr_d <= addr_w;
            q_w    <= (g == 2) ? prog[addr_d] : prog[addr_w];
        end

        always @(posedge clk) begin
            done_a  <= valid_w & ready_w;
            flags_a <= (valid_w && ready_w && op_w == fault_op) ? fault_flags : 3'b000;
            if (valid_w && ready_w) log_q.push_back({op_w, imm_w});
            if (valid_w) vcnt <= vcnt + 1;
        end

        assign ready_w = auto_mode ? 1'b1 : man_ready;
        assign done_w  = auto_mode ? done_a : man_done;
        assign flags_w = auto_mode ? flags_a : man_flags;

        assign halted_v[g] = halted_w;
        assign busy_v[g]   = busy_w;
        assign valid_v[g]  = valid_w;
        assign pc_v[g]     = pc_w;
        assign ovf_v[g]    = ovf_w;
        assign op_v[g]     = op_w;
        assign imm_v[g]    = imm_w;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) prog[i] = 11'h000;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        g_dut[0].log_q.delete();
        g_dut[2].log_q.delete();
    endtask

    task automatic wait_halt(input int idx, input int budget, output int cycles);
        cycles = 0;
        while (!halted_v[idx] && cycles < budget) begin
            tick();
            cycles++;
        end
        check("halt_reached", 32'(halted_v[idx]), 32'd1);
    endtask

    initial begin
        int cyc;
        int cyc2;
        int vsnap;
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        run         = 1'b0;
        step        = 1'b0;
        auto_mode   = 1'b1;
        man_ready   = 1'b0;
        man_done    = 1'b0;
        man_flags   = 3'b000;
        fault_op    = 3'b000;
        fault_flags = 3'b001;
        fill_nop();

        // Reset state
        tick();
        tick();
        check("rst_pc", 32'(pc_v[0]), 32'd0);
        check("rst_ovf", 32'(ovf_v[0]), 32'd0);
        check("rst_dp", {20'd0, valid_v[0], op_v[0], imm_v[0]}, 32'd0);
        check("rst_busy_halt", {30'd0, busy_v[0], halted_v[0]}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Test 1: PUSH 5, PUSH 3, ADD, HALT
        prog[0] = {3'b001, 8'd5};
        prog[1] = {3'b001, 8'd3};
        prog[2] = {3'b011, 8'd0};
        prog[3] = {3'b111, 8'd0};
        do_reset();
        pulse_run();
        check("t1_busy", 32'(busy_v[0]), 32'd1);
        wait_halt(0, 60, cyc);
        check("t1_cycles", cyc, 17);
        check("t1_pc", 32'(pc_v[0]), 32'd3);
        check("t1_ovf", 32'(ovf_v[0]), 32'd0);
        check("t1_nops", g_dut[0].log_q.size(), 3);
        if (g_dut[0].log_q.size() == 3) begin
            check("t1_op0", 32'(g_dut[0].log_q[0]), {21'd0, 3'b001, 8'd5});
            check("t1_op1", 32'(g_dut[0].log_q[1]), {21'd0, 3'b001, 8'd3});
            check("t1_op2", 32'(g_dut[0].log_q[2]), {21'd0, 3'b011, 8'd0});
        end
        wait_halt(2, 60, cyc2);
        check("t1_lat2_cycles", cyc + cyc2, 21);
        check("t1_lat2_pc", 32'(pc_v[2]), 32'd3);
        check("t1_lat2_nops", g_dut[2].log_q.size(), 3);
        if (g_dut[2].log_q.size() == 3)
            check("t1_lat2_op1", 32'(g_dut[2].log_q[1]), {21'd0, 3'b001, 8'd3});

        // Test 2: fault on ADD
        prog[0]  = {3'b001, 8'd100};
        prog[1]  = {3'b001, 8'd100};
        fault_op = 3'b011;
        do_reset();
        pulse_run();
        wait_halt(0, 60, cyc);
        check("t2_pc", 32'(pc_v[0]), 32'd2);
        check("t2_ovf", 32'(ovf_v[0]), 32'd1);
        vsnap = g_dut[0].vcnt;
        for (int i = 0; i < 5; i++) tick();
        check("t2_no_valid", g_dut[0].vcnt, vsnap);
        check("t2_still_halted", 32'(halted_v[0]), 32'd1);
        pulse_run();
        check("t2_restart_pc", 32'(pc_v[0]), 32'd0);
        check("t2_restart_ovf", 32'(ovf_v[0]), 32'd0);
        check("t2_restart_busy", {30'd0, busy_v[0], halted_v[0]}, 32'd2);
        fault_op = 3'b000;

        // Test 3: JMP 7, HALT at 7
        fill_nop();
        prog[0] = {3'b110, 8'h07};
        prog[7] = {3'b111, 8'd0};
        do_reset();
        vsnap = g_dut[0].vcnt;
        pulse_run();
        wait_halt(0, 40, cyc);
        check("t3_pc", 32'(pc_v[0]), 32'd7);
        check("t3_no_valid", g_dut[0].vcnt, vsnap);

        // Test 4: all NOP, wrap vs no wrap
        fill_nop();
        do_reset();
        pulse_run();
        wait_halt(1, 100, cyc);
        check("t4_nowrap_cycles", cyc, 48);
        check("t4_nowrap_pc", 32'(pc_v[1]), 32'd15);
        check("t4_wrap_pc", 32'(pc_v[0]), 32'd0);
        check("t4_wrap_running", 32'(halted_v[0]), 32'd0);

        // Test 5: ready stall, then reset during DPWAIT
        prog[1]   = {3'b001, 8'hFD};
        prog[2]   = {3'b111, 8'd0};
        auto_mode = 1'b0;
        do_reset();
        pulse_run();
        cyc = 0;
        while (!valid_v[0] && cyc < 20) begin
            tick();
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            check("t5_hold", {20'd0, valid_v[0], op_v[0], imm_v[0]}, {20'd0, 1'b1, 3'b001, 8'hFD});
            tick();
        end
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        check("t5_dpwait", {29'd0, valid_v[0], busy_v[0], halted_v[0]}, 32'd2);
        check("t5_pc_before", 32'(pc_v[0]), 32'd1);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t5_rst_pc", 32'(pc_v[0]), 32'd0);
        check("t5_rst_state", {29'd0, valid_v[0], busy_v[0], halted_v[0]}, 32'd0);
        man_done  = 1'b1;
        man_flags = 3'b111;
        tick();
        man_done  = 1'b0;
        man_flags = 3'b000;
        tick();
        check("t5_late_done", {27'd0, ovf_v[0], busy_v[0], halted_v[0]}, 32'd0);
        auto_mode = 1'b1;

        // Test 6: single step on the ROM_LAT=2 instance
        fill_nop();
        prog[0] = {3'b001, 8'h07};
        prog[2] = {3'b110, 8'h05};
        prog[5] = {3'b111, 8'd0};
        step = 1'b1;
        do_reset();
        pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t6_s1_pc", 32'(pc_v[2]), 32'd1);
        check("t6_s1_state", {30'd0, busy_v[2], halted_v[2]}, 32'd0);
        check("t6_s1_nops", g_dut[2].log_q.size(), 1);
        if (g_dut[2].log_q.size() == 1)
            check("t6_s1_op", 32'(g_dut[2].log_q[0]), {21'd0, 3'b001, 8'h07});
        pulse_run();
        for (int i = 0; i < 10; i++) tick();
        check("t6_s2_pc", 32'(pc_v[2]), 32'd2);
        pulse_run();
        for (int i = 0; i < 10; i++) tick();
        check("t6_s3_pc", 32'(pc_v[2]), 32'd5);
        check("t6_s3_halt", 32'(halted_v[2]), 32'd0);
        pulse_run();
        for (int i = 0; i < 10; i++) tick();
        check("t6_s4_pc", 32'(pc_v[2]), 32'd5);
        check("t6_s4_halt", 32'(halted_v[2]), 32'd1);
        step = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
